xoclk_ctrl: RTL and testbench

- Programmable clock-pattern controller that drives the 4-bit DDR output serializer from the i_clk domain.
- 4-subsample numerically-controlled oscillator (NCO) produces one 4-bit word per i_clk, MSB-first in time.
- Frequency changes are accepted through a valid/ready handshake and applied only at a phase wrap, so the generated clock never glitches.
- A timeout forces the update through if no wrap occurs.

---
 rtl/xoclk_pkg.sv | 23 ++
 rtl/xoclk_nco.sv | 44 ++++
 rtl/xoclk_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_xoclk_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/xoclk_pkg.sv
// Shared types and constant helpers for the xoclk clock-pattern controller.
package xoclk_pkg;

  localparam int XO_PW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_RAMP = 2'd3
  } xo_state_e;

  // Largest step that keeps the NCO below Nyquist: 2^(pw-1)-1.
  function automatic logic [63:0] xo_step_max(input int pw);
    return (64'd1 << (pw - 1)) - 64'd1;
  endfunction

  // Per-wrap step change limit used when ramping: 2^(pw-8).
  function automatic logic [63:0] xo_ramp_delta(input int pw);
    return 64'd1 << (pw - 8);
  endfunction

endpackage

// File: rtl/xoclk_nco.sv
// 4-subsample NCO: phase accumulator, sub-phase adders, registered MSB-first word and wrap flag.
module xoclk_nco
  import xoclk_pkg::*;
#(
  parameter int PW = XO_PW
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_run,
  input  logic          i_clear,
  input  logic [PW-1:0] i_step,
  output logic [3:0]    o_word,
  output logic          o_wrap
);

  logic [PW-1:0] r_phase;
  logic [3:0]    r_word;
  logic [PW-1:0] w_p1;
  logic [PW-1:0] w_p2;
  logic [PW-1:0] w_p3;
  logic [PW+1:0] w_sum4;

  assign w_p1   = r_phase + i_step;
  assign w_p2   = r_phase + {i_step[PW-2:0], 1'b0};
  assign w_p3   = w_p1 + {i_step[PW-2:0], 1'b0};
  // Two spare bits hold the carry of phase+4*step; any of them set means a wrap.
  assign w_sum4 = {2'b00, r_phase} + {i_step, 2'b00};
  assign o_wrap = i_run & (w_sum4[PW+1:PW] != 2'b00);
  assign o_word = r_word;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_phase <= '0;
      r_word  <= 4'b0000;
    end else if (!i_run) begin
      r_phase <= '0;
      r_word  <= 4'b0000;
    end else begin
      r_word  <= {r_phase[PW-1], w_p1[PW-1], w_p2[PW-1], w_p3[PW-1]};
      r_phase <= i_clear ? '0 : w_sum4[PW-1:0];
    end
  end

endmodule

// File: rtl/xoclk_ctrl.sv
// Clock-pattern controller: step handshake, glitch-free update at phase wrap, timeout force.
// Optional macro XOCLK_RAMP_EN replaces the single-jump update with a rate-limited ramp.
module xoclk_ctrl
  import xoclk_pkg::*;
#(
  parameter int PW      = XO_PW,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [PW-1:0] i_cfg_step,
  output logic [3:0]    o_word,
  output logic          o_active,
  output logic [PW-1:0] o_step,
  output logic          o_forced
);

  localparam logic [PW-1:0] L_STEP_MAX = PW'(xo_step_max(PW));
  localparam logic [TW-1:0] L_TMO_LAST = TW'(TIMEOUT - 1);

  xo_state_e     r_state;
  xo_state_e     w_next;
  logic [PW-1:0] r_step;
  logic [PW-1:0] r_pending;
  logic [TW-1:0] r_timer;
  logic          r_ready;
  logic          r_active;
  logic          r_forced;

  logic          w_accept;
  logic          w_wrap;
  logic          w_tmo;
  logic          w_run;
  logic          w_clr;
  logic          w_forced;
  logic          w_load_step;
  logic          w_load_pend;
  logic [PW-1:0] w_step_in;
  logic [PW-1:0] w_new_step;

`ifdef XOCLK_RAMP_EN
  localparam logic [PW-1:0] L_RAMP_DELTA = PW'(xo_ramp_delta(PW));

  function automatic logic [PW-1:0] ramp_next(input logic [PW-1:0] cur, input logic [PW-1:0] tgt);
    logic [PW-1:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      ramp_next = (diff > L_RAMP_DELTA) ? (cur + L_RAMP_DELTA) : tgt;
    end else begin
      diff = cur - tgt;
      ramp_next = (diff > L_RAMP_DELTA) ? (cur - L_RAMP_DELTA) : tgt;
    end
  endfunction
`endif

  assign w_accept  = i_cfg_valid & r_ready;
  assign w_step_in = (i_cfg_step > L_STEP_MAX) ? L_STEP_MAX : i_cfg_step;
  assign w_tmo     = (r_timer == L_TMO_LAST);

  assign o_cfg_ready = r_ready;
  assign o_active    = r_active;
  assign o_step      = r_step;
  assign o_forced    = r_forced;

  xoclk_nco #(.PW(PW)) u_nco (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_run      (w_run),
    .i_clear    (w_clr),
    .i_step     (r_step),
    .o_word     (o_word),
    .o_wrap     (w_wrap)
  );

  // Next-state and datapath control decode.
  always_comb begin
    w_next      = r_state;
    w_run       = 1'b0;
    w_clr       = 1'b0;
    w_forced    = 1'b0;
    w_load_step = 1'b0;
    w_load_pend = 1'b0;
    w_new_step  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_cfg_step != '0)) begin
          w_load_step = 1'b1;
          w_new_step  = w_step_in;
          w_next      = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_accept) begin
          w_load_pend = 1'b1;
`ifdef XOCLK_RAMP_EN
          w_next = ST_RAMP;
`else
          w_next = ST_PEND;
`endif
        end else begin
          w_next = ST_RUN;
        end
      end
`ifdef XOCLK_RAMP_EN
      ST_RAMP: begin
        w_run = 1'b1;
        if (w_wrap || w_tmo) begin
          w_load_step = 1'b1;
          w_new_step  = ramp_next(r_step, r_pending);
          w_forced    = ~w_wrap;
          if (w_new_step != r_pending) begin
            w_clr  = ~w_wrap;
            w_next = ST_RAMP;
          end else if (r_pending == '0) begin
            w_clr  = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_clr  = ~w_wrap;
            w_next = ST_RUN;
          end
        end else begin
          w_next = ST_RAMP;
        end
      end
`else
      ST_PEND: begin
        w_run = 1'b1;
        // A wrap in the same cycle as the timeout takes the clean path.
        if (w_wrap || w_tmo) begin
          w_load_step = 1'b1;
          w_new_step  = r_pending;
          w_forced    = ~w_wrap;
          w_clr       = ~w_wrap | (r_pending == '0);
          w_next      = (r_pending == '0) ? ST_IDLE : ST_RUN;
        end else begin
          w_next = ST_PEND;
        end
      end
`endif
      default: begin
        w_clr  = 1'b1;
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, step registers, timer and registered status outputs.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_pending <= '0;
      r_timer   <= '0;
      r_ready   <= 1'b1;
      r_active  <= 1'b0;
      r_forced  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ready  <= (w_next == ST_IDLE) || (w_next == ST_RUN);
      r_active <= (w_next != ST_IDLE);
      r_forced <= w_forced;
      if (w_load_step) begin
        r_step <= w_new_step;
      end else begin
        r_step <= r_step;
      end
      if (w_load_pend) begin
        r_pending <= w_step_in;
      end else begin
        r_pending <= r_pending;
      end
      if (w_load_pend || w_load_step) begin
        r_timer <= '0;
      end else if ((r_state == ST_PEND) || (r_state == ST_RAMP)) begin
        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        r_timer <= r_timer;
      end
    end
  end

endmodule

// File: tb/tb_xoclk_ctrl.sv
// Directed self-checking bench for xoclk_ctrl (default single-jump build).
module tb_xoclk_ctrl;

  logic        i_clk = 1'b0;
  logic        i_areset_n;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [31:0] i_cfg_step;
  logic [3:0]  o_word;
  logic        o_active;
  logic [31:0] o_step;
  logic        o_forced;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  xoclk_ctrl #(.PW(32), .TIMEOUT(1024), .TW(11)) dut (
    .i_clk       (i_clk),
    .i_areset_n  (i_areset_n),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_step  (i_cfg_step),
    .o_word      (o_word),
    .o_active    (o_active),
    .o_step      (o_step),
    .o_forced    (o_forced)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s);
    i_cfg_valid = 1'b1;
    i_cfg_step  = s;
    tick();
    i_cfg_valid = 1'b0;
    i_cfg_step  = 32'h0;
  endtask

  task automatic apply_reset();
    i_cfg_valid = 1'b0;
    i_cfg_step  = 32'h0;
    tick();
    #2;
    i_areset_n = 1'b0;
    #3;
    i_areset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    i_areset_n  = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_step  = 32'h0;
    #23;
    checks++; if (o_word !== 4'b0000) begin failures++; $display("FAIL reset_word got=%b exp=0000", o_word); end
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_cfg_ready); end
    checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", o_active); end
    checks++; if (o_step !== 32'h0) begin failures++; $display("FAIL reset_step got=%h exp=0", o_step); end
    checks++; if (o_forced !== 1'b0) begin failures++; $display("FAIL reset_forced got=%b exp=0", o_forced); end
    i_areset_n = 1'b1;
    tick();
    // Zero step in IDLE is ignored.
    send(32'h0);
    checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL zero_idle_active got=%b exp=0", o_active); end
    checks++; if (o_step !== 32'h0) begin failures++; $display("FAIL zero_idle_step got=%h exp=0", o_step); end
    tick();
    checks++; if (o_word !== 4'b0000) begin failures++; $display("FAIL zero_idle_word got=%b exp=0000", o_word); end
  endtask

  task automatic test_quarter_rate();
    apply_reset();
    send(32'h4000_0000);
    checks++; if (o_active !== 1'b1) begin failures++; $display("FAIL quarter_active got=%b exp=1", o_active); end
    checks++; if (o_word !== 4'b0000) begin failures++; $display("FAIL quarter_first got=%b exp=0000", o_word); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (o_word !== 4'b0011) begin failures++; $display("FAIL quarter_word cyc=%0d got=%b exp=0011", k, o_word); end
    end
  endtask

  task automatic test_update_at_wrap();
    apply_reset();
    send(32'h2000_0000);
    tick();
    checks++; if (o_word !== 4'b0000) begin failures++; $display("FAIL upd_word0 got=%b exp=0000", o_word); end
    send(32'h4000_0000);
    checks++; if (o_word !== 4'b1111) begin failures++; $display("FAIL upd_word1 got=%b exp=1111", o_word); end
    checks++; if (o_cfg_ready !== 1'b0) begin failures++; $display("FAIL upd_ready_pend got=%b exp=0", o_cfg_ready); end
    tick();
    checks++; if (o_word !== 4'b0000) begin failures++; $display("FAIL upd_word2 got=%b exp=0000", o_word); end
    checks++; if (o_step !== 32'h2000_0000) begin failures++; $display("FAIL upd_step_old got=%h exp=20000000", o_step); end
    tick();
    checks++; if (o_word !== 4'b1111) begin failures++; $display("FAIL upd_word3 got=%b exp=1111", o_word); end
    checks++; if (o_step !== 32'h4000_0000) begin failures++; $display("FAIL upd_step_new got=%h exp=40000000", o_step); end
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL upd_ready_run got=%b exp=1", o_cfg_ready); end
    checks++; if (o_forced !== 1'b0) begin failures++; $display("FAIL upd_forced got=%b exp=0", o_forced); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_word !== 4'b0011) begin failures++; $display("FAIL upd_after cyc=%0d got=%b exp=0011", k, o_word); end
    end
  endtask

  task automatic test_clamp_and_same_step();
    // Running at 0x4000_0000 with a wrap every cycle.
    send(32'h4000_0000);
    checks++; if (o_cfg_ready !== 1'b0) begin failures++; $display("FAIL same_ready got=%b exp=0", o_cfg_ready); end
    tick();
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL same_back got=%b exp=1", o_cfg_ready); end
    checks++; if (o_step !== 32'h4000_0000) begin failures++; $display("FAIL same_step got=%h exp=40000000", o_step); end
    send(32'hF000_0000);
    checks++; if (o_step !== 32'h4000_0000) begin failures++; $display("FAIL clamp_pend_step got=%h exp=40000000", o_step); end
    tick();
    checks++; if (o_step !== 32'h7FFF_FFFF) begin failures++; $display("FAIL clamp_run got=%h exp=7fffffff", o_step); end
    apply_reset();
    send(32'hF000_0000);
    checks++; if (o_step !== 32'h7FFF_FFFF) begin failures++; $display("FAIL clamp_idle got=%h exp=7fffffff", o_step); end
  endtask

  task automatic test_timeout();
    int n;
    bit found;
    apply_reset();
    send(32'h0000_0001);
    tick();
    tick();
    send(32'h4000_0000);
    checks++; if (o_cfg_ready !== 1'b0) begin failures++; $display("FAIL tmo_ready0 got=%b exp=0", o_cfg_ready); end
    n = 0;
    found = 1'b0;
    for (int k = 1; k <= 1100 && !found; k++) begin
      tick();
      if (o_step == 32'h4000_0000) begin
        found = 1'b1;
        n = k;
      end else begin
        checks++; if (o_cfg_ready !== 1'b0) begin failures++; $display("FAIL tmo_ready_pend cyc=%0d got=%b exp=0", k, o_cfg_ready); end
      end
    end
    checks++; if (n != 1024) begin failures++; $display("FAIL tmo_latency got=%0d exp=1024", n); end
    checks++; if (o_forced !== 1'b1) begin failures++; $display("FAIL tmo_forced got=%b exp=1", o_forced); end
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL tmo_ready1 got=%b exp=1", o_cfg_ready); end
    tick();
    checks++; if (o_forced !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", o_forced); end
    checks++; if (o_word !== 4'b0011) begin failures++; $display("FAIL tmo_word got=%b exp=0011", o_word); end
  endtask

  task automatic test_stop();
    apply_reset();
    send(32'h2000_0000);
    tick();
    send(32'h0);
    tick();
    checks++; if (o_active !== 1'b1) begin failures++; $display("FAIL stop_active_pend got=%b exp=1", o_active); end
    tick();
    checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL stop_active got=%b exp=0", o_active); end
    checks++; if (o_step !== 32'h0) begin failures++; $display("FAIL stop_step got=%h exp=0", o_step); end
    checks++; if (o_word !== 4'b1111) begin failures++; $display("FAIL stop_last_word got=%b exp=1111", o_word); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_word !== 4'b0000) begin failures++; $display("FAIL stop_word cyc=%0d got=%b exp=0000", k, o_word); end
    end
  endtask

  task automatic test_reset_mid_pend();
    apply_reset();
    send(32'h0000_0001);
    tick();
    send(32'h4000_0000);
    tick();
    tick();
    #2;
    i_areset_n = 1'b0;
    #1;
    checks++; if (o_step !== 32'h0) begin failures++; $display("FAIL rst_pend_step got=%h exp=0", o_step); end
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_pend_ready got=%b exp=1", o_cfg_ready); end
    checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL rst_pend_active got=%b exp=0", o_active); end
    #3;
    i_areset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_step !== 32'h0) begin failures++; $display("FAIL rst_discard cyc=%0d got=%h exp=0", k, o_step); end
    end
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_after_ready got=%b exp=1", o_cfg_ready); end
    send(32'h4000_0000);
    tick();
    checks++; if (o_word !== 4'b0011) begin failures++; $display("FAIL rst_restart got=%b exp=0011", o_word); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_quarter_rate();
    test_update_at_wrap();
    test_clamp_and_same_step();
    test_timeout();
    test_stop();
    test_reset_mid_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
